// File: rtl/in_request_responder_pkg.sv
// Shared types for the CPU IN responder: FSM encoding and the zero-extension helper.
package in_request_responder_pkg;

    localparam int LARGURA_DADO   = 32;
    localparam int LARGURA_CHAVES = 4;

    typedef enum logic [2:0] {
        OCIOSO         = 3'd0,
        SOLTURA_PREVIA = 3'd1,
        AGUARDA        = 3'd2,
        CAPTURA        = 3'd3,
        SOLTURA        = 3'd4
    } estado_t;

    function automatic logic [LARGURA_DADO-1:0] estende_zero(input logic [LARGURA_CHAVES-1:0] v);
        return {{(LARGURA_DADO-LARGURA_CHAVES){1'b0}}, v};
    endfunction

endpackage

// File: rtl/in_request_responder_debounce_botao.sv
// Button synchroniser + debouncer; stable level changes after DEBOUNCE_CYCLES stable cycles.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles from raw edge to press_evt; no backpressure.
module debounce_botao #(
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int SYNC_STAGES       = 2,
    parameter bit BOTAO_ATIVO_BAIXO = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic botao_bruto,
    output logic estavel,
    output logic press_evt
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sinc_q;
    logic [CW-1:0]          cnt_q;
    logic                   estavel_d1_q;
    logic                   nivel;

    assign nivel     = sinc_q[SYNC_STAGES-1] ^ BOTAO_ATIVO_BAIXO;
    assign press_evt = estavel & ~estavel_d1_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            // Chain resets to the raw "released" level so no spurious press follows reset.
            sinc_q       <= {SYNC_STAGES{BOTAO_ATIVO_BAIXO}};
            cnt_q        <= '0;
            estavel      <= 1'b0;
            estavel_d1_q <= 1'b0;
        end else begin
            sinc_q       <= {sinc_q[SYNC_STAGES-2:0], botao_bruto};
            estavel_d1_q <= estavel;
            if (nivel != estavel) begin
                if (cnt_q == CNT_MAX) begin
                    estavel <= ~estavel;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/in_request_responder.sv
// Responder for the CPU IN handshake: stalls the core until an operator press, then returns the switches.
// Latency: dado_valido one cycle after the debounced press; the core is held via pausa while waiting.
module in_request_responder
    import in_request_responder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int SYNC_STAGES       = 2,
    parameter bit BOTAO_ATIVO_BAIXO = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    comando_in,
    input  logic                    botao_placa,
    input  logic [LARGURA_CHAVES-1:0] entrada_dados,
    output logic                    pausa,
    output logic                    dado_valido,
    output logic [LARGURA_DADO-1:0] dado_lido,
    output logic                    led_in,
    output logic                    botao_estavel
);
    estado_t estado_q, estado_d;
    logic    pendente_q, pendente_d;
    logic    captura;
    logic    press_evt;
    logic [SYNC_STAGES-1:0][LARGURA_CHAVES-1:0] chaves_sinc_q;

    debounce_botao #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .SYNC_STAGES      (SYNC_STAGES),
        .BOTAO_ATIVO_BAIXO(BOTAO_ATIVO_BAIXO)
    ) u_debounce (
        .clock      (clock),
        .reset      (reset),
        .botao_bruto(botao_placa),
        .estavel    (botao_estavel),
        .press_evt  (press_evt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q      <= OCIOSO;
            pendente_q    <= 1'b0;
            dado_lido     <= '0;
            chaves_sinc_q <= '0;
        end else begin
            estado_q      <= estado_d;
            pendente_q    <= pendente_d;
            chaves_sinc_q <= {chaves_sinc_q[SYNC_STAGES-2:0], entrada_dados};
            if (captura) begin
                dado_lido <= estende_zero(chaves_sinc_q[SYNC_STAGES-1]);
            end
        end
    end

    always_comb begin
        estado_d    = estado_q;
        pendente_d  = pendente_q;
        captura     = 1'b0;
        pausa       = 1'b0;
        led_in      = 1'b0;
        dado_valido = 1'b0;
        unique case (estado_q)
            OCIOSO: begin
                pendente_d = 1'b0;
                // A press already held when the request arrives must be released first.
                if (comando_in) estado_d = botao_estavel ? SOLTURA_PREVIA : AGUARDA;
            end
            SOLTURA_PREVIA: begin
                pausa  = 1'b1;
                led_in = 1'b1;
                if (!comando_in)         estado_d = OCIOSO;
                else if (!botao_estavel) estado_d = AGUARDA;
            end
            AGUARDA: begin
                pausa  = 1'b1;
                led_in = 1'b1;
                if (!comando_in) begin
                    estado_d = OCIOSO;
                end else if (press_evt) begin
                    estado_d = CAPTURA;
                    captura  = 1'b1;
                end
            end
            CAPTURA: begin
                dado_valido = 1'b1;
                estado_d    = SOLTURA;
            end
            SOLTURA: begin
                if (comando_in) pendente_d = 1'b1;
                // A request seen before release waits for a fresh press, never reuses this one.
                if (!botao_estavel) begin
                    estado_d   = (pendente_q || comando_in) ? AGUARDA : OCIOSO;
                    pendente_d = 1'b0;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

endmodule

// File: tb/tb_in_request_responder.sv
// Directed bench for in_request_responder with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, active-low button.
module tb_in_request_responder;
    logic        clock = 1'b0;
    logic        reset;
    logic        comando_in;
    logic        botao_placa;
    logic [3:0]  entrada_dados;
    logic        pausa;
    logic        dado_valido;
    logic [31:0] dado_lido;
    logic        led_in;
    logic        botao_estavel;

    int erros   = 0;
    int checks  = 0;
    int n_valid = 0;
    int ciclos;
    logic viu_estavel;

    // Raw press edge -> 2 sync + 4 debounce cycles -> press_evt, then CAPTURA one cycle later.
    localparam int LAT_VALIDO = 7;

    in_request_responder #(
        .DEBOUNCE_CYCLES  (4),
        .SYNC_STAGES      (2),
        .BOTAO_ATIVO_BAIXO(1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .comando_in   (comando_in),
        .botao_placa  (botao_placa),
        .entrada_dados(entrada_dados),
        .pausa        (pausa),
        .dado_valido  (dado_valido),
        .dado_lido    (dado_lido),
        .led_in       (led_in),
        .botao_estavel(botao_estavel)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (dado_valido) n_valid++;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s: got=%h expected=%h", tag, obs, esp);
        end
    endtask

    task automatic ciclo(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Advances until dado_valido is seen; returns the cycle count or -1 when the budget runs out.
    task automatic espera_valido(input int limite, output int n);
        n = -1;
        for (int i = 1; i <= limite; i++) begin
            ciclo();
            if (dado_valido) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        comando_in    = 1'b0;
        botao_placa   = 1'b1;
        entrada_dados = 4'h0;
        ciclo(3);
        verifica("rst_pausa", {31'b0, pausa}, 32'd0);
        verifica("rst_valido", {31'b0, dado_valido}, 32'd0);
        verifica("rst_dado", dado_lido, 32'd0);
        verifica("rst_led", {31'b0, led_in}, 32'd0);
        verifica("rst_estavel", {31'b0, botao_estavel}, 32'd0);
        reset = 1'b0;
        ciclo(2);

        // Basic capture
        entrada_dados = 4'b1010;
        comando_in    = 1'b1;
        ciclo();
        verifica("basic_pausa_up", {31'b0, pausa}, 32'd1);
        verifica("basic_led_up", {31'b0, led_in}, 32'd1);
        botao_placa = 1'b0;
        espera_valido(20, ciclos);
        verifica("basic_latency", ciclos, LAT_VALIDO);
        verifica("basic_dado", dado_lido, 32'h0000000A);
        verifica("basic_pausa_cap", {31'b0, pausa}, 32'd0);
        comando_in = 1'b0;
        ciclo();
        verifica("basic_pulse_1cyc", {31'b0, dado_valido}, 32'd0);
        verifica("basic_led_soltura", {31'b0, led_in}, 32'd0);
        ciclo(2);
        botao_placa = 1'b1;
        ciclo(8);
        verifica("basic_n_valid", n_valid, 32'd1);
        verifica("basic_idle_pausa", {31'b0, pausa}, 32'd0);

        // Glitch reject, then abort in AGUARDA
        comando_in = 1'b1;
        ciclo();
        botao_placa = 1'b0;
        ciclo(3);
        botao_placa = 1'b1;
        viu_estavel = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ciclo();
            if (botao_estavel) viu_estavel = 1'b1;
        end
        verifica("glitch_estavel", {31'b0, viu_estavel}, 32'd0);
        verifica("glitch_pausa", {31'b0, pausa}, 32'd1);
        verifica("glitch_n_valid", n_valid, 32'd1);
        entrada_dados = 4'h6;
        comando_in    = 1'b0;
        ciclo();
        verifica("abort_pausa", {31'b0, pausa}, 32'd0);
        verifica("abort_led", {31'b0, led_in}, 32'd0);
        ciclo(3);
        verifica("abort_dado_kept", dado_lido, 32'h0000000A);

        // Held press before the request
        entrada_dados = 4'h5;
        botao_placa   = 1'b0;
        ciclo(8);
        verifica("held_estavel", {31'b0, botao_estavel}, 32'd1);
        comando_in = 1'b1;
        ciclo();
        verifica("held_pausa", {31'b0, pausa}, 32'd1);
        ciclo(10);
        verifica("held_no_capture", n_valid, 32'd1);
        botao_placa   = 1'b1;
        entrada_dados = 4'hC;
        ciclo(8);
        verifica("held_released", {31'b0, botao_estavel}, 32'd0);
        verifica("held_still_pausa", {31'b0, pausa}, 32'd1);
        verifica("held_n_valid", n_valid, 32'd1);
        botao_placa = 1'b0;
        espera_valido(20, ciclos);
        verifica("held_latency", ciclos, LAT_VALIDO);
        verifica("held_dado", dado_lido, 32'h0000000C);
        comando_in = 1'b0;
        ciclo();

        // Back-to-back: next request arrives while the button is still held
        entrada_dados = 4'h3;
        comando_in    = 1'b1;
        ciclo(5);
        verifica("b2b_soltura_pausa", {31'b0, pausa}, 32'd0);
        verifica("b2b_no_reuse", n_valid, 32'd2);
        botao_placa = 1'b1;
        ciclo(8);
        verifica("b2b_wait_pausa", {31'b0, pausa}, 32'd1);
        verifica("b2b_wait_n_valid", n_valid, 32'd2);
        botao_placa = 1'b0;
        espera_valido(20, ciclos);
        verifica("b2b_latency", ciclos, LAT_VALIDO);
        verifica("b2b_dado", dado_lido, 32'h00000003);
        comando_in = 1'b0;
        ciclo();
        botao_placa = 1'b1;
        ciclo(8);
        verifica("b2b_idle_pausa", {31'b0, pausa}, 32'd0);
        verifica("b2b_n_valid", n_valid, 32'd3);

        // Reset mid-request
        comando_in = 1'b1;
        ciclo();
        verifica("rstmid_pausa_up", {31'b0, pausa}, 32'd1);
        reset = 1'b1;
        ciclo();
        verifica("rstmid_pausa", {31'b0, pausa}, 32'd0);
        verifica("rstmid_led", {31'b0, led_in}, 32'd0);
        verifica("rstmid_valido", {31'b0, dado_valido}, 32'd0);
        verifica("rstmid_dado", dado_lido, 32'd0);
        verifica("rstmid_estavel", {31'b0, botao_estavel}, 32'd0);
        reset      = 1'b0;
        comando_in = 1'b0;
        ciclo();
        botao_placa = 1'b0;
        ciclo(10);
        verifica("rstmid_press_seen", {31'b0, botao_estavel}, 32'd1);
        botao_placa = 1'b1;
        ciclo(10);
        verifica("rstmid_no_valid", n_valid, 32'd3);
        verifica("rstmid_pausa_idle", {31'b0, pausa}, 32'd0);

        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

endmodule

// File: doc/in_request_responder.md
Name: in_request_responder

Overview:
- Responder side of the CPU IN handshake.
- The control unit raises comando_in and the core stalls. This block waits for a debounced press of the board button, captures the 4-bit switch value, returns it zero-extended to 32 bits and releases the stall.
- Sits between the board pins (botao, switches) and the CPU input datapath / stall logic. It also replaces the missing button debounce.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable clock cycles needed to accept a button level change (minimum 2).
- SYNC_STAGES, 2, flip-flop stages on the button and switch inputs (minimum 2).
- BOTAO_ATIVO_BAIXO, 1, 1 = raw button reads 0 when pressed.

Ports:
- clock  input  1  single system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- comando_in  input  1  CPU requests an input word; level, sampled each cycle.
- botao_placa  input  1  raw asynchronous push-button.
- entrada_dados  input  4  raw asynchronous switches.
- pausa  output  1  stall request to the core; high while a request is waiting for data.
- dado_valido  output  1  one-cycle pulse; dado_lido is new this cycle.
- dado_lido  output  32  captured value, {28'b0, switches}; held until the next capture.
- led_in  output  1  high while waiting for the operator press.
- botao_estavel  output  1  debounced, polarity-corrected button level (1 = pressed); for debug.

Behaviour:
- Reset values (synchronous, active-high): pausa=0, dado_valido=0, dado_lido=0, led_in=0, botao_estavel=0, state=OCIOSO, pending=0, debounce counter=0, sync chains cleared to the "released" level.
- Synchronisation:
  - botao_placa and entrada_dados each pass through SYNC_STAGES flops.
  - The button is inverted when BOTAO_ATIVO_BAIXO=1.
- Debounce:
  - Counter compares the synced level with botao_estavel.
  - On mismatch the counter increments; on match it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, botao_estavel toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes botao_estavel.
  - press_evt is a one-cycle pulse on the 0->1 transition of botao_estavel.
- FSM states:
  - OCIOSO: if comando_in=1 -> AGUARDA. If botao_estavel=1 at that moment, go to SOLTURA_PREVIA instead, so a press held from before the request is not accepted.
  - SOLTURA_PREVIA: pausa=1, led_in=1; on botao_estavel=0 -> AGUARDA.
  - AGUARDA: pausa=1, led_in=1; on press_evt -> CAPTURA.
  - CAPTURA (1 cycle):
    - dado_lido <= {28'b0, synced switches}, sampled on the cycle press_evt was high.
    - dado_valido=1 and pausa=0 in this cycle.
    - -> SOLTURA.
  - SOLTURA: pausa=0, led_in=0.
    - If comando_in=1, set pending=1.
    - On botao_estavel=0: go to AGUARDA if pending (clear pending), else OCIOSO.
    - One press can never satisfy two requests.
- Timing:
  - pausa rises on the cycle after comando_in is first sampled high.
  - dado_valido occurs exactly 1 cycle after press_evt.
  - press_evt occurs DEBOUNCE_CYCLES+SYNC_STAGES cycles after a clean raw press (±1).
- Other rules:
  - comando_in dropping while in AGUARDA or SOLTURA_PREVIA: return to OCIOSO, pausa=0, no capture (request aborted by the core, e.g. context switch).
  - Reset mid-operation: immediate return to reset values on the next edge; any captured-but-unread data is lost.
  - Switch changes outside CAPTURA never affect dado_lido.

Decomposition:
- Shared package:
  - FSM state encoding (OCIOSO, SOLTURA_PREVIA, AGUARDA, CAPTURA, SOLTURA; 3 bits).
  - Constant for the zero-extension width (32).
- Sub-module debounce_botao (sync chain + counter + stable level + edge pulse). Parameterised by DEBOUNCE_CYCLES, SYNC_STAGES and BOTAO_ATIVO_BAIXO; reused later for the reset button.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, BOTAO_ATIVO_BAIXO=1):
- Basic capture: switches=4'b1010, comando_in=1, then botao low for 10 cycles.
  -> pausa=1 one cycle after comando_in.
  -> dado_valido pulses once with dado_lido=32'h0000000A; pausa=0 in that cycle.
- Glitch reject: while in AGUARDA, botao low for 3 cycles then high.
  -> no press_evt, pausa stays 1, dado_valido never pulses.
- Held press: botao already low when comando_in rises.
  -> state SOLTURA_PREVIA, no capture until release plus a new 4-cycle press; then dado_lido = switches at the new press.
- Back-to-back: second comando_in during SOLTURA with switches=4'h3.
  -> no second dado_valido until release and a new press; then dado_lido=32'h3.
- Abort: comando_in dropped in AGUARDA.
  -> pausa=0 next cycle, state OCIOSO, dado_lido unchanged.
- Reset mid-request: reset=1 for 1 cycle during AGUARDA.
  -> all outputs 0 on the next edge; a subsequent press without comando_in gives no dado_valido.
